fx68k_useq: RTL and testbench



---
 rtl/fx68k_useq_pkg.sv | 33 +++
 rtl/fx68k_useq_next.sv | 51 +++++
 rtl/fx68k_useq.sv | 123 ++++++++++++
 tb/tb_fx68k_useq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx68k_useq_pkg.sv
// ============================================================================
// Module : fx68k_useq_pkg
// Brief  : Shared types and microword field positions for the fx68k sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fx68k_useq_pkg;

    typedef enum logic [2:0] {
        BT_DIRECT  = 3'd0,
        BT_COND    = 3'd1,
        BT_DISP_A1 = 3'd2,
        BT_DISP_A2 = 3'd3,
        BT_DISP_A3 = 3'd4,
        BT_IRQCHK  = 3'd5,
        BT_HALT    = 3'd6,
        BT_RSVD    = 3'd7
    } btype_e;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EXEC = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int NMA_LSB   = 0;
    localparam int BTYPE_LSB = 10;
    localparam int CSEL_LSB  = 13;

endpackage

`default_nettype wire

// File: rtl/fx68k_useq_next.sv
// ============================================================================
// Module : fx68k_useq_next
// Brief  : Combinational next micro-address select from the microword branch
//          fields
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fx68k_useq_next
    import fx68k_useq_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VEC    = 10'h001
) (
    input  logic [ADDR_WIDTH-1:0] i_nma,
    input  logic [2:0]            i_btype,
    input  logic [3:0]            i_csel,
    input  logic [ADDR_WIDTH-1:0] i_upc,
    input  logic [15:0]           i_cond,
    input  logic [ADDR_WIDTH-1:0] i_a1,
    input  logic [ADDR_WIDTH-1:0] i_a2,
    input  logic [ADDR_WIDTH-1:0] i_a3,
    input  logic                  i_irq_pend,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_halt_req
);

    btype_e w_btype;

    assign w_btype = btype_e'(i_btype);

    always_comb begin
        o_next_addr = i_nma;
        o_halt_req  = 1'b0;
        case (w_btype)
            BT_DIRECT:  o_next_addr = i_nma;
            // Fall-through address wraps naturally at the address width.
            BT_COND:    o_next_addr = i_cond[i_csel] ? i_nma
                                                     : i_upc + ADDR_WIDTH'(1);
            BT_DISP_A1: o_next_addr = i_a1;
            BT_DISP_A2: o_next_addr = i_a2;
            BT_DISP_A3: o_next_addr = i_a3;
            BT_IRQCHK:  o_next_addr = i_irq_pend ? IRQ_VEC : i_nma;
            BT_HALT:    o_halt_req  = 1'b1;
            default:    o_next_addr = i_nma;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fx68k_useq.sv
// ============================================================================
// Module : fx68k_useq
// Brief  : Microcode sequencer feeding fx68kRom; waits out ROM latency and
//          branches on the returned microword
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fx68k_useq
    import fx68k_useq_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROM_LAT    = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VEC  = 10'h000,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VEC    = 10'h001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_ena,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic [15:0]           cond,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic                  irq_pend,
    input  logic                  stall,
    input  logic                  resume,
    output logic [DATA_WIDTH-1:0] uword,
    output logic                  uword_valid,
    output logic [ADDR_WIDTH-1:0] upc,
    output logic                  halted
);

    localparam logic [1:0] c_rom_lat = 2'(ROM_LAT);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_upc;
    logic [ADDR_WIDTH-1:0] w_upc_nxt;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_halt_req;

    fx68k_useq_next #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IRQ_VEC    (IRQ_VEC)
    ) u_next (
        .i_nma       (rom_q[NMA_LSB +: ADDR_WIDTH]),
        .i_btype     (rom_q[BTYPE_LSB +: 3]),
        .i_csel      (rom_q[CSEL_LSB +: 4]),
        .i_upc       (r_upc),
        .i_cond      (cond),
        .i_a1        (a1),
        .i_a2        (a2),
        .i_a3        (a3),
        .i_irq_pend  (irq_pend),
        .o_next_addr (w_next_addr),
        .o_halt_req  (w_halt_req)
    );

    // The ROM address and upc always move together, so one register serves both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_cnt   <= c_rom_lat;
            r_upc   <= RESET_VEC;
        end else if (clk_ena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_upc   <= w_upc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_upc_nxt   = r_upc;
        case (r_state)
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Stall freezes the branch decision; inputs are only sampled on exit.
                if (!stall) begin
                    if (w_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_upc_nxt   = w_next_addr;
                        w_cnt_nxt   = c_rom_lat;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_upc_nxt   = RESET_VEC;
                    w_cnt_nxt   = c_rom_lat;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_upc_nxt   = RESET_VEC;
                w_cnt_nxt   = c_rom_lat;
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    assign rom_addr    = r_upc;
    assign upc         = r_upc;
    assign uword       = rom_q;
    assign uword_valid = (r_state == ST_EXEC);
    assign halted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fx68k_useq.sv
// ============================================================================
// Module : tb_fx68k_useq
// Brief  : Scoreboard bench for fx68k_useq with a latency-2 ROM model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fx68k_useq;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_ena = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [15:0]   cond = '0;
    logic [AW-1:0] a1 = '0, a2 = '0, a3 = '0;
    logic          irq_pend = 1'b0, stall = 1'b0, resume = 1'b0;
    logic [DW-1:0] uword;
    logic          uword_valid;
    logic [AW-1:0] upc;
    logic          halted;

    int checks = 0;
    int failures = 0;

    fx68k_useq #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_LAT    (LAT),
        .RESET_VEC  (10'h000),
        .IRQ_VEC    (10'h001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_ena     (clk_ena),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .cond        (cond),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .irq_pend    (irq_pend),
        .stall       (stall),
        .resume      (resume),
        .uword       (uword),
        .uword_valid (uword_valid),
        .upc         (upc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // ROM with registered address and registered output, both gated by clk_ena.
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] rom_addr_q;
    always @(posedge clk) begin
        if (clk_ena) begin
            rom_addr_q <= rom_addr;
            rom_q      <= mem[rom_addr_q];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input int bt, input int csel, input int nma);
        logic [DW-1:0] w;
        w        = $urandom;
        w[9:0]   = nma[9:0];
        w[12:10] = bt[2:0];
        w[16:13] = csel[3:0];
        return w;
    endfunction

    // Reference model: counts enabled edges spent fetching, presenting or halted.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
    } exp_t;
    exp_t          sb[$];
    int            m_mode;     // 0 fetching, 1 presenting, 2 halted
    int            m_wait;
    logic [AW-1:0] m_upc;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        logic [AW-1:0] nma;
        int            bt;
        int            cs;
        if (!rst_n) begin
            m_mode = 0;
            m_wait = LAT;
            m_upc  = '0;
            sb.delete();
        end else if (clk_ena) begin
            if (m_mode == 0) begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    m_mode = 1;
                    sb.push_back('{addr: m_upc, word: mem[m_upc]});
                end
            end else if (m_mode == 1) begin
                if (!stall) begin
                    w   = mem[m_upc];
                    nma = w[9:0];
                    bt  = int'(w[12:10]);
                    cs  = int'(w[16:13]);
                    if (bt == 6) begin
                        m_mode = 2;
                    end else begin
                        if (bt == 1)      m_upc = cond[cs] ? nma : AW'((int'(m_upc) + 1) % 1024);
                        else if (bt == 2) m_upc = a1;
                        else if (bt == 3) m_upc = a2;
                        else if (bt == 4) m_upc = a3;
                        else if (bt == 5) m_upc = irq_pend ? 10'h001 : nma;
                        else              m_upc = nma;
                        m_mode = 0;
                        m_wait = LAT;
                    end
                end
            end else if (resume) begin
                m_upc  = '0;
                m_mode = 0;
                m_wait = LAT;
            end
        end
    end

    // Monitor: pops one expectation per new presentation, checks holds in between.
    logic          prev_valid = 1'b0;
    logic [DW-1:0] held_word;
    logic [AW-1:0] pres_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            chk("valid", 64'(uword_valid), 64'(m_mode == 1));
            chk("halted", 64'(halted), 64'(m_mode == 2));
            chk("upc", 64'(upc), 64'(m_upc));
            chk("rom_addr", 64'(rom_addr), 64'(m_upc));
            if (uword_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'(0), 64'(1));
                end else begin
                    e = sb.pop_front();
                    chk("pres_upc", 64'(upc), 64'(e.addr));
                    chk("pres_word", 64'(uword), 64'(e.word));
                    pres_q.push_back(upc);
                end
                held_word = uword;
            end else if (uword_valid) begin
                chk("stall_word", 64'(uword), 64'(held_word));
            end
            prev_valid = uword_valid;
        end
    end

    initial begin
        logic [AW-1:0] exp_seq [0:6];
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h000] = mkword(0, 0, 10'h123);
        mem[10'h123] = mkword(0, 0, 10'h040);
        mem[10'h040] = mkword(3, 0, 10'h3C3);
        mem[10'h2AA] = mkword(5, 0, 10'h010);
        mem[10'h001] = mkword(0, 0, 10'h3FF);
        mem[10'h3FF] = mkword(1, 5, 10'h055);
        exp_seq = '{10'h000, 10'h123, 10'h040, 10'h2AA, 10'h001, 10'h3FF, 10'h000};

        clk_ena = 1'b1; a2 = 10'h2AA; irq_pend = 1'b1; cond = '0;
        #2;
        chk("rst_rom_addr", 64'(rom_addr), 64'(0));
        chk("rst_upc", 64'(upc), 64'(0));
        chk("rst_valid", 64'(uword_valid), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed chain with clk_ena alternating 1,0.
        pres_q.delete();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1 clk_ena = ~clk_ena;
        end
        chk("chain_len", 64'(pres_q.size() >= 7), 64'(1));
        for (int i = 0; i < 7; i++) begin
            if (i < pres_q.size()) chk("chain_upc", 64'(pres_q[i]), 64'(exp_seq[i]));
        end

        // Randomized program and inputs.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h3FF] = mkword(1, 5, 10'h055);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            clk_ena  = ($urandom % 4) != 0;
            stall    = ($urandom % 3) == 0;
            cond     = 16'($urandom);
            a1       = AW'($urandom);
            a2       = AW'($urandom);
            a3       = AW'($urandom);
            irq_pend = 1'($urandom);
            resume   = ($urandom % 4) == 0;
        end

        // Asynchronous reset in the middle of a fetch wait.
        clk_ena = 1'b1; stall = 1'b0; resume = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (!uword_valid && !halted && rom_addr != '0) found = 1'b1;
        end
        chk("found_wait", 64'(found), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rom_addr", 64'(rom_addr), 64'(0));
        chk("async_upc", 64'(upc), 64'(0));
        chk("async_valid", 64'(uword_valid), 64'(0));
        chk("async_halted", 64'(halted), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
